// File: rtl/alert_pkg.sv
// Shared alert-level definitions: level encoding, timer width and saturation value.
// Also used by the downstream containment FSM.
package alert_pkg;

  localparam int TIMER_W = 6;
  localparam logic [TIMER_W-1:0] TIMER_MAX = 6'd63;

  typedef enum logic [1:0] {
    LVL_GREEN  = 2'b00,
    LVL_YELLOW = 2'b01,
    LVL_RED    = 2'b10
  } level_t;

  // Light pattern {green, yellow, red}; an illegal code shows GREEN.
  function automatic logic [2:0] level_lights(input level_t lvl);
    logic [2:0] lights;
    case (lvl)
      LVL_GREEN:  lights = 3'b100;
      LVL_YELLOW: lights = 3'b010;
      LVL_RED:    lights = 3'b001;
      default:    lights = 3'b100;
    endcase
    return lights;
  endfunction

endpackage

// File: rtl/sat_timer.sv
// Saturating up-counter with synchronous active-low reset, synchronous clear and enable.
// Clear takes priority over enable; the count holds once it reaches MAX.
module sat_timer #(
  parameter int             W   = 6,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_q;

  // Count register: reset, clear, saturating increment.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_q <= ZERO;
    end else if (clr) begin
      r_q <= ZERO;
    end else if (en && (r_q != MAX)) begin
      r_q <= r_q + ONE;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/alert_level_gen.sv
// Turns motion/breach/all_clear pulses into registered one-hot alert lights plus a level timer.
// Optional macro ALERT_BREACH_CNT_EN adds a saturating 4-bit breach counter output.
module alert_level_gen
  import alert_pkg::*;
#(
  parameter logic [TIMER_W-1:0] YELLOW_HOLD = 6'd30,
  parameter logic [TIMER_W-1:0] RED_MIN     = 6'd25
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               motion,
  input  logic               breach,
  input  logic               all_clear,
  output logic               green,
  output logic               yellow,
  output logic               red,
  output logic [TIMER_W-1:0] timer,
  output logic [1:0]         level
`ifdef ALERT_BREACH_CNT_EN
  ,
  output logic [3:0]         breach_cnt
`endif
);

  level_t             r_state;
  level_t             w_next;
  logic               w_restart;
  logic               w_clr;
  logic [TIMER_W-1:0] w_timer;
  logic               r_green;
  logic               r_yellow;
  logic               r_red;

  // Next level and timer-restart decision; priority is breach > all_clear > motion.
  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    case (r_state)
      LVL_GREEN: begin
        if (breach) begin
          w_next = LVL_RED;
        end else if (motion) begin
          w_next = LVL_YELLOW;
        end else begin
          w_next = LVL_GREEN;
        end
      end
      LVL_YELLOW: begin
        if (breach) begin
          w_next = LVL_RED;
        end else if (all_clear) begin
          w_next = LVL_GREEN;
        end else if (motion) begin
          w_restart = 1'b1;
        end else if (w_timer == (YELLOW_HOLD - 6'd1)) begin
          w_next = LVL_GREEN;
        end else begin
          w_next = LVL_YELLOW;
        end
      end
      LVL_RED: begin
        // all_clear before RED_MIN is simply dropped, not latched.
        if (breach) begin
          w_restart = 1'b1;
        end else if (all_clear && (w_timer >= RED_MIN)) begin
          w_next = LVL_YELLOW;
        end else begin
          w_next = LVL_RED;
        end
      end
      default: begin
        w_next    = LVL_GREEN;
        w_restart = 1'b1;
      end
    endcase
  end

  assign w_clr = w_restart || (w_next != r_state);

  // Level state and light registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= LVL_GREEN;
      r_green  <= 1'b1;
      r_yellow <= 1'b0;
      r_red    <= 1'b0;
    end else begin
      r_state                      <= w_next;
      {r_green, r_yellow, r_red}   <= level_lights(w_next);
    end
  end

  sat_timer #(
    .W   (TIMER_W),
    .MAX (TIMER_MAX)
  ) u_level_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (w_clr),
    .en      (1'b1),
    .q       (w_timer)
  );

`ifdef ALERT_BREACH_CNT_EN
  logic [3:0] w_breach_cnt;

  sat_timer #(
    .W   (4),
    .MAX (4'd15)
  ) u_breach_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (1'b0),
    .en      (breach),
    .q       (w_breach_cnt)
  );

  assign breach_cnt = w_breach_cnt;
`endif

  assign green  = r_green;
  assign yellow = r_yellow;
  assign red    = r_red;
  assign timer  = w_timer;
  assign level  = r_state;

endmodule

// File: doc/alert_level_gen.md
Name: alert_level_gen

Overview:
- Upstream stage of the containment FSM.
- Turns raw facility sensor pulses (motion, breach, all-clear) into the one-hot green/yellow/red alert lights and the 6-bit timer that the containment FSM consumes.
- The timer counts clock cycles since the current alert level was entered, so downstream thresholds (e.g. 25, 35) mean "cycles spent at this level".

Parameters:
- YELLOW_HOLD, 6'd30: cycles at YELLOW with no new motion before auto de-escalation to GREEN; legal range 1..62.
- RED_MIN, 6'd25: minimum cycles at RED before all_clear is honoured; legal range 1..62.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- motion  in  1  motion-sensor event; level-sampled each cycle.
- breach  in  1  containment-breach event; level-sampled each cycle.
- all_clear  in  1  operator all-clear; level-sampled each cycle.
- green  out  1  alert level GREEN (registered).
- yellow  out  1  alert level YELLOW (registered).
- red  out  1  alert level RED (registered).
- timer  out  6  cycles since the current level was entered; saturates at 63.
- level  out  2  encoded level: 00 GREEN, 01 YELLOW, 10 RED; 11 never driven.

Behaviour:
- Reset: on any posedge with reset_n=0, level=GREEN, green=1, yellow=0, red=0, timer=0. Reset overrides all events and applies mid-operation from any state.
- Outputs are registered:
  - Inputs are sampled at posedge k; the new level and lights are visible after posedge k.
  - Latency is 1 cycle, with no combinational path from inputs to outputs.
  - green/yellow/red are always exactly one-hot and always match level.
- Event priority when several are asserted in the same cycle: breach > all_clear > motion.
- GREEN:
  - breach -> RED.
  - else motion -> YELLOW.
  - all_clear is ignored.
  - Otherwise stay.
- YELLOW:
  - breach -> RED.
  - else all_clear -> GREEN.
  - else motion -> stay and restart timer (timer=0 next cycle).
  - else if timer == YELLOW_HOLD-1 -> GREEN.
  - Otherwise stay.
- RED:
  - breach -> stay and restart timer.
  - else all_clear with timer >= RED_MIN -> YELLOW.
  - all_clear with timer < RED_MIN is ignored and not remembered.
  - motion is ignored.
- Timer:
  - On any level change or restart, timer=0 in the cycle the new level appears.
  - Otherwise timer increments by 1 each cycle, saturating at 63 (63 holds; no wrap).
  - Timer value t means the level has been shown for t+1 edges.
- The state register uses only the three legal encodings; an illegal state recovers to GREEN with timer=0 on the next edge.

Optional Feature:
- Macro: ALERT_BREACH_CNT_EN.
- Defined:
  - Adds output breach_cnt [3:0], reset to 0.
  - Increments on every cycle in which breach=1 (including breach while already RED) and saturates at 15.
  - Not cleared by all_clear; cleared only by reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alert_pkg holds:
  - the level encoding constants (LVL_GREEN=2'b00, LVL_YELLOW=2'b01, LVL_RED=2'b10);
  - the 2-bit level typedef;
  - TIMER_W=6 and TIMER_MAX=6'd63, shared with the containment FSM.
- One sub-module, sat_timer:
  - parameterised width;
  - synchronous clear and enable;
  - saturating count.
  - Instantiated once for timer; reused for breach_cnt when ALERT_BREACH_CNT_EN is defined.

Test Plan:
- Reset then idle 100 cycles -> green=1, level=00, timer climbs 0..63 then holds 63; no wrap.
- From GREEN, motion pulse 1 cycle -> next cycle yellow=1, timer=0; no further events -> GREEN exactly 30 cycles after entry, timer=0.
- In YELLOW, motion again at timer=20 -> timer=0 and YELLOW held; GREEN only 30 cycles after the second motion.
- breach, all_clear and motion all asserted together from GREEN -> RED, timer=0.
- all_clear at RED timer=10 -> ignored.
- all_clear at RED timer=25 -> YELLOW next cycle, timer=0.
- reset_n low for 1 cycle while RED at timer=40 -> green=1, timer=0 after that edge.
- With ALERT_BREACH_CNT_EN, 20 breach cycles -> breach_cnt saturates at 15; without it, the port does not exist.
